event_ram_sched: RTL and testbench
==================================

EVENT_RAM_SCHED -- requirements
Module: event_ram_sched

Interface
REQ-001 SHALL have parameter IMWIDTH, default 240, frame width in pixels.
REQ-002 SHALL have parameter IMHEIGHT, default 180, frame height in pixels.
REQ-003 SHALL have parameter STARVE_MAX, default 4, maximum consecutive event grants while a scan read is pending.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports evValid in 1, evX in 8, evY in 8, evReady out 1: event write request and handshake.
REQ-007 SHALL have ports scanStart in 1, scanBusy out 1, scanDone out 1: frame scan control.
REQ-008 SHALL have ports ramX out 8, ramY out 8, ramEventIn out 1, ramWrite out 1, ramPixel in 1: imageROM xAddr/yAddr/eventIn/write/pixelValue.
REQ-009 SHALL have ports win out 9, winMedian out 1, winValid out 1, winX out 8, winY out 8: 3x3 window, binary median, centre.
REQ-010 SHALL have port dropCount, output, 8, count of out-of-range events.

Function
REQ-011 SHALL treat RAM reads as 1-cycle latency: ramPixel valid in the cycle after address presented with ramWrite=0.
REQ-012 SHALL implement states IDLE and SCAN; IDLE->SCAN on scanStart; SCAN->IDLE the cycle after the final window's winValid.
REQ-013 SHALL ignore scanStart while in SCAN.
REQ-014 SHALL grant an event (evReady=1, combinational) when evValid=1 and (state=IDLE or streak<STARVE_MAX).
REQ-015 SHALL, on an in-range grant (evX<IMWIDTH and evY<IMHEIGHT), drive ramWrite=1, ramEventIn=1, ramX=evX, ramY=evY in that cycle.
REQ-016 SHALL, on an out-of-range grant, keep ramWrite=0 and increment dropCount, saturating at 255.
REQ-017 SHALL, in SCAN with no event granted, issue one read: ramWrite=0, ramEventIn=0, ramX/ramY = current tap address.
REQ-018 SHALL increment streak on each event grant in SCAN and clear it on each issued scan read; streak is 0 in IDLE.
REQ-019 SHALL scan centres y=1..IMHEIGHT-2 (outer), x=1..IMWIDTH-2 (inner): 238x178=42364 windows at defaults.
REQ-020 SHALL read taps k=0..8 per window at (x+(k%3)-1, y+(k/3)-1); win[k] = captured ramPixel for tap k.
REQ-021 SHALL hold tap index and centre when an event takes the slot; a stalled read is reissued, never skipped.
REQ-022 SHALL issue the next window's tap 0 in the cycle after tap 8 of the previous window when uncontested.
REQ-023 SHALL assert winValid for one cycle, registered, the cycle after tap 8 data is captured, with win, winX, winY stable that cycle.
REQ-024 SHALL set winMedian=1 iff popcount(win)>=5.
REQ-025 SHALL pulse scanDone for one cycle coincident with the final winValid; scanBusy=1 exactly while in SCAN.
REQ-026 SHALL drive ramX=0, ramY=0, ramWrite=0, ramEventIn=0 in any cycle with neither grant nor read.
REQ-027 SHALL make reads reflect RAM contents at issue time; no coherency with concurrent event writes.
REQ-028 SHALL time uncontested first scan: tap k issued in cycle k+1 after the scanStart edge; first winValid in cycle 11; then every 9 cycles.

Reset
REQ-029 SHALL, on reset, enter IDLE and clear streak, tap index, centre, dropCount, win, winMedian, winValid, winX, winY, scanBusy, scanDone, ramX, ramY, ramWrite, ramEventIn.
REQ-030 SHALL abort a scan on reset mid-operation; no winValid or scanDone follows until a new scanStart.
REQ-031 SHALL drive evReady=0 while reset is high.

Verification
REQ-032 Idle event: evValid=1, evX=10, evY=20 -> same cycle evReady=1, ramWrite=1, ramEventIn=1, ramX=10, ramY=20.
REQ-033 Out of range: evX=240, evY=5 -> evReady=1, ramWrite=0, dropCount 0->1; 300 such events -> dropCount=255.
REQ-034 Uncontested scan, RAM all 1 except (1,1)=0 -> first winValid cycle 11, winX=1, winY=1, win=9'h1EF, winMedian=1; scanDone with winX=238, winY=178 after 42364 windows.
REQ-035 Starvation: evValid held 1 during SCAN -> pattern 4 grants, 1 read (evReady=0), repeating; tap sequence unbroken, win data correct.
REQ-036 Reset asserted mid-scan at window 100 -> next cycle scanBusy=0, all outputs 0; no winValid until scanStart reissued.
REQ-037 scanStart pulsed during SCAN -> ignored; window count and scanDone timing identical to single-start run.

Source files
------------

// File: rtl/event_ram_sched_if.sv
// event_ram_sched_if
//   Bundles the event-write handshake, scan control, image RAM port,
//   window output and drop counter of event_ram_sched.
//   slave  : the scheduler side (event_ram_sched)
//   master : the side that feeds events, starts scans, hosts the RAM
//            and consumes windows
interface event_ram_sched_if;
   logic       evValid;
   logic [7:0] evX;
   logic [7:0] evY;
   logic       evReady;
   logic       scanStart;
   logic       scanBusy;
   logic       scanDone;
   logic [7:0] ramX;
   logic [7:0] ramY;
   logic       ramEventIn;
   logic       ramWrite;
   logic       ramPixel;
   logic [8:0] win;
   logic       winMedian;
   logic       winValid;
   logic [7:0] winX;
   logic [7:0] winY;
   logic [7:0] dropCount;

   modport slave (
      input  evValid, evX, evY, scanStart, ramPixel,
      output evReady, scanBusy, scanDone, ramX, ramY, ramEventIn, ramWrite,
             win, winMedian, winValid, winX, winY, dropCount
   );

   modport master (
      output evValid, evX, evY, scanStart, ramPixel,
      input  evReady, scanBusy, scanDone, ramX, ramY, ramEventIn, ramWrite,
             win, winMedian, winValid, winX, winY, dropCount
   );
endinterface

// File: rtl/event_ram_sched.sv
// event_ram_sched
//   Shares one single-port image RAM between incoming pixel events and a
//   3x3 window scan of the frame. Events win the RAM slot, but after
//   STARVE_MAX consecutive event grants during a scan one cycle is forced
//   to the pending scan read. Each window is emitted with its binary
//   median once all nine taps have returned.
// Ports
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus.ev*    : event write request / combinational grant (evReady)
//   bus.scan*  : scan start, busy while scanning, done with final window
//   bus.ram*   : RAM address/data/write, ramPixel returns one cycle later
//   bus.win*   : 3x3 window bits, median, valid strobe, centre coordinates
//   bus.dropCount : saturating count of out-of-range events
//
// state | meaning
// IDLE  | no scan; events always granted
// SCAN  | walking window centres, reading taps into free RAM slots
module event_ram_sched #(
   parameter int IMWIDTH    = 240,
   parameter int IMHEIGHT   = 180,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            reset,
   event_ram_sched_if.slave bus
);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [8:0]    XLIM       = 9'(IMWIDTH);
   localparam logic [8:0]    YLIM       = 9'(IMHEIGHT);
   localparam logic [7:0]    XLAST      = 8'(IMWIDTH - 2);
   localparam logic [7:0]    YLAST      = 8'(IMHEIGHT - 2);
   localparam logic [SW-1:0] STREAK_LIM = SW'(STARVE_MAX);

   typedef enum logic {IDLE, SCAN} stateT;

   stateT         state;
   logic [SW-1:0] streak;
   logic [3:0]    tap;
   logic [7:0]    cx, cy;
   logic          allIssued;
   logic          rdPend;
   logic [3:0]    rdTap;
   logic [7:0]    rdCx, rdCy;
   logic          grant, inRange, rdIssue;
   logic [7:0]    tapDx, tapDy;

   logic [8:0]    winR;
   logic          winMedianR, winValidR, scanDoneR;
   logic [7:0]    winXR, winYR, dropCountR;

   assign bus.win       = winR;
   assign bus.winMedian = winMedianR;
   assign bus.winValid  = winValidR;
   assign bus.winX      = winXR;
   assign bus.winY      = winYR;
   assign bus.scanDone  = scanDoneR;
   assign bus.dropCount = dropCountR;
   assign bus.scanBusy  = (state == SCAN);

   always_comb begin
      inRange = ({1'b0, bus.evX} < XLIM) && ({1'b0, bus.evY} < YLIM);
      grant   = !reset && bus.evValid && ((state == IDLE) || (streak < STREAK_LIM));
      // A read goes out only into a slot no event took, until the last tap is out.
      rdIssue = !reset && (state == SCAN) && !grant && !allIssued;

      case (tap)
         4'd1, 4'd4, 4'd7: tapDx = 8'd1;
         4'd2, 4'd5, 4'd8: tapDx = 8'd2;
         default:          tapDx = 8'd0;
      endcase
      case (tap)
         4'd3, 4'd4, 4'd5: tapDy = 8'd1;
         4'd6, 4'd7, 4'd8: tapDy = 8'd2;
         default:          tapDy = 8'd0;
      endcase

      bus.evReady    = grant;
      bus.ramX       = 8'd0;
      bus.ramY       = 8'd0;
      bus.ramWrite   = 1'b0;
      bus.ramEventIn = 1'b0;
      if (grant && inRange) begin
         bus.ramX       = bus.evX;
         bus.ramY       = bus.evY;
         bus.ramWrite   = 1'b1;
         bus.ramEventIn = 1'b1;
      end else if (rdIssue) begin
         bus.ramX = cx + tapDx - 8'd1;
         bus.ramY = cy + tapDy - 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         streak     <= '0;
         tap        <= '0;
         cx         <= '0;
         cy         <= '0;
         allIssued  <= 1'b0;
         rdPend     <= 1'b0;
         rdTap      <= '0;
         rdCx       <= '0;
         rdCy       <= '0;
         winR       <= '0;
         winMedianR <= 1'b0;
         winValidR  <= 1'b0;
         winXR      <= '0;
         winYR      <= '0;
         scanDoneR  <= 1'b0;
         dropCountR <= '0;
      end else begin
         winValidR <= 1'b0;
         scanDoneR <= 1'b0;
         rdPend    <= rdIssue;

         if (grant && !inRange && (dropCountR != 8'hFF))
            dropCountR <= dropCountR + 8'd1;

         if (rdPend) begin
            winR[rdTap] <= bus.ramPixel;
            if (rdTap == 4'd8) begin
               winValidR  <= 1'b1;
               winXR      <= rdCx;
               winYR      <= rdCy;
               // win[8] is still in flight, so fold ramPixel in directly.
               winMedianR <= ($countones({bus.ramPixel, winR[7:0]}) >= 5);
               // Only the final tap 8 can return once every read is issued.
               scanDoneR  <= allIssued;
            end
         end

         case (state)
            IDLE: begin
               streak <= '0;
               if (bus.scanStart) begin
                  state     <= SCAN;
                  tap       <= '0;
                  cx        <= 8'd1;
                  cy        <= 8'd1;
                  allIssued <= 1'b0;
               end
            end
            SCAN: begin
               if (scanDoneR) begin
                  state  <= IDLE;
                  streak <= '0;
               end else if (grant) begin
                  streak <= streak + SW'(1);
               end else if (rdIssue) begin
                  streak <= '0;
               end

               // Tap and centre advance only when the read actually went out.
               if (rdIssue) begin
                  rdTap <= tap;
                  rdCx  <= cx;
                  rdCy  <= cy;
                  if (tap == 4'd8) begin
                     tap <= '0;
                     if (cx == XLAST) begin
                        cx <= 8'd1;
                        if (cy == YLAST) allIssued <= 1'b1;
                        else             cy <= cy + 8'd1;
                     end else begin
                        cx <= cx + 8'd1;
                     end
                  end else begin
                     tap <= tap + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_event_ram_sched.sv
// tb_event_ram_sched
//   Drives event_ram_sched with directed and random traffic, hosts the
//   image RAM, and compares every cycle against a transaction-level model:
//   the model walks a flat tap index through the frame, reads its own copy
//   of the image and queues the expected windows with their due cycle.
module tb_event_ram_sched;
   localparam int W    = 24;
   localparam int H    = 22;
   localparam int SMAX = 4;
   localparam int NX   = W - 2;
   localparam int NWIN = NX * (H - 2);
   localparam int NTAP = NWIN * 9;

   typedef struct {
      int         cyc;
      logic [7:0] x;
      logic [7:0] y;
      logic [8:0] w;
      bit         last;
   } winT;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   bit   fillEn = 1'b0;
   always #5 clk = ~clk;

   event_ram_sched_if bus();

   event_ram_sched #(.IMWIDTH(W), .IMHEIGHT(H), .STARVE_MAX(SMAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   bit mem [256][256];
   always @(posedge clk) begin
      if (fillEn) begin
         for (int yy = 0; yy < 256; yy++)
            for (int xx = 0; xx < 256; xx++)
               mem[yy][xx] <= !(xx == 1 && yy == 1);
      end else if (bus.ramWrite) begin
         mem[bus.ramY][bus.ramX] <= bus.ramEventIn;
      end
      bus.ramPixel <= mem[bus.ramY][bus.ramX];
   end

   int nCompared = 0;
   int nMismatch = 0;

   bit         img [256][256];
   bit         mScan = 1'b0;
   int         mStreak = 0, mIdx = 0, mEnd = -1, mDrop = 0;
   logic [8:0] mWin = '0;
   winT        expQ[$];
   int         cyc = 0, startCyc = 0;
   int         dutWinCnt = 0, firstWinCyc = -1, doneCyc = -1;
   logic [8:0] firstW = '0;
   logic [7:0] firstX = '0, firstY = '0, doneX = '0, doneY = '0;
   logic       firstMed = 1'b0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatch++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic step(input bit ev, input logic [7:0] x, input logic [7:0] y,
                       input bit ss, input bit rst);
      bit  grant, inR, rd;
      int  w, k, cx, cy, ax, ay, exX, exY;
      winT e;
      @(negedge clk);
      reset         = rst;
      bus.evValid   = ev;
      bus.evX       = x;
      bus.evY       = y;
      bus.scanStart = ss;
      #1;
      inR   = (int'(x) < W) && (int'(y) < H);
      grant = !rst && ev && (!mScan || mStreak < SMAX);
      rd    = !rst && mScan && !grant && (mIdx < NTAP);
      w = mIdx / 9;  k = mIdx % 9;
      cx = 1 + w % NX;  cy = 1 + w / NX;
      ax = cx + k % 3 - 1;  ay = cy + k / 3 - 1;

      checkVal("evReady",    32'(bus.evReady),    32'(grant));
      checkVal("ramWrite",   32'(bus.ramWrite),   32'(grant && inR));
      checkVal("ramEventIn", 32'(bus.ramEventIn), 32'(grant && inR));
      if (!(grant && !inR)) begin
         exX = grant ? int'(x) : (rd ? ax : 0);
         exY = grant ? int'(y) : (rd ? ay : 0);
         checkVal("ramX", 32'(bus.ramX), 32'(exX));
         checkVal("ramY", 32'(bus.ramY), 32'(exY));
      end
      checkVal("scanBusy",  32'(bus.scanBusy),  32'(mScan));
      checkVal("dropCount", 32'(bus.dropCount), 32'(mDrop));
      if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
         e = expQ.pop_front();
         checkVal("winValid",  32'(bus.winValid),  32'd1);
         checkVal("winX",      32'(bus.winX),      32'(e.x));
         checkVal("winY",      32'(bus.winY),      32'(e.y));
         checkVal("win",       32'(bus.win),       32'(e.w));
         checkVal("winMedian", 32'(bus.winMedian), 32'($countones(e.w) >= 5));
         checkVal("scanDone",  32'(bus.scanDone),  32'(e.last));
      end else begin
         checkVal("winValid", 32'(bus.winValid), 32'd0);
         checkVal("scanDone", 32'(bus.scanDone), 32'd0);
      end
      if (bus.winValid) begin
         dutWinCnt++;
         if (firstWinCyc < 0) begin
            firstWinCyc = cyc;  firstW = bus.win;
            firstX = bus.winX;  firstY = bus.winY;  firstMed = bus.winMedian;
         end
         if (bus.scanDone) begin
            doneCyc = cyc;  doneX = bus.winX;  doneY = bus.winY;
         end
      end

      if (rst) begin
         mScan = 1'b0;  mStreak = 0;  mIdx = 0;  mEnd = -1;  mDrop = 0;
         expQ.delete();
      end else begin
         if (grant && !inR && mDrop < 255) mDrop++;
         if (grant && inR) img[y][x] = 1'b1;
         if (rd) begin
            mWin[k] = img[ay][ax];
            if (k == 8) begin
               e.cyc = cyc + 2;  e.x = 8'(cx);  e.y = 8'(cy);
               e.w = mWin;  e.last = (mIdx == NTAP - 1);
               expQ.push_back(e);
            end
            mIdx++;
            if (mIdx == NTAP) mEnd = cyc + 2;
            mStreak = 0;
         end else if (mScan && grant) begin
            mStreak++;
         end
         if (mScan && cyc == mEnd) begin
            mScan = 1'b0;  mStreak = 0;
         end else if (!mScan && ss) begin
            mScan = 1'b1;  mIdx = 0;  mEnd = -1;  mStreak = 0;
            startCyc = cyc;  firstWinCyc = -1;  doneCyc = -1;  dutWinCnt = 0;
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
   endtask

   initial begin
      int i, winsBefore;
      bus.evValid = 1'b0;  bus.evX = '0;  bus.evY = '0;  bus.scanStart = 1'b0;

      // reset state
      step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
      step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
      step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
      checkVal("rstWin",   32'(bus.win),      32'd0);
      checkVal("rstWinX",  32'(bus.winX),     32'd0);
      checkVal("rstWinY",  32'(bus.winY),     32'd0);
      checkVal("rstMed",   32'(bus.winMedian), 32'd0);

      // idle in-range event
      step(1'b1, 8'd10, 8'd20, 1'b0, 1'b0);
      checkVal("idleEvReady", 32'(bus.evReady),  32'd1);
      checkVal("idleEvWrite", 32'(bus.ramWrite), 32'd1);
      checkVal("idleEvX",     32'(bus.ramX),     32'd10);
      checkVal("idleEvY",     32'(bus.ramY),     32'd20);

      // out-of-range events and saturation
      step(1'b1, 8'd240, 8'd5, 1'b0, 1'b0);
      checkVal("oorReady", 32'(bus.evReady),  32'd1);
      checkVal("oorWrite", 32'(bus.ramWrite), 32'd0);
      idle(1);
      checkVal("drop1", 32'(bus.dropCount), 32'd1);
      for (i = 0; i < 300; i++) step(1'b1, 8'd240, 8'd5, 1'b0, 1'b0);
      idle(1);
      checkVal("dropSat", 32'(bus.dropCount), 32'd255);

      // all-ones frame with (1,1)=0, uncontested scan, stray scanStart mid-scan
      fillEn = 1'b1;
      idle(1);
      fillEn = 1'b0;
      for (int yy = 0; yy < 256; yy++)
         for (int xx = 0; xx < 256; xx++)
            img[yy][xx] = !(xx == 1 && yy == 1);
      step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
      for (i = 0; i < NTAP + 50; i++) begin
         step(1'b0, 8'd0, 8'd0, (i == 500), 1'b0);
         if (doneCyc >= 0 && !mScan) break;
      end
      checkVal("scan1Finished", 32'(doneCyc >= 0), 32'd1);
      checkVal("firstWinCycle", 32'(firstWinCyc - startCyc), 32'd11);
      checkVal("firstWin",      32'(firstW),   32'h1EF);
      checkVal("firstWinX",     32'(firstX),   32'd1);
      checkVal("firstWinY",     32'(firstY),   32'd1);
      checkVal("firstMedian",   32'(firstMed), 32'd1);
      checkVal("doneCycle",     32'(doneCyc - startCyc), 32'(11 + 9 * (NWIN - 1)));
      checkVal("doneWinX",      32'(doneX), 32'(W - 2));
      checkVal("doneWinY",      32'(doneY), 32'(H - 2));
      checkVal("scan1WinCount", 32'(dutWinCnt), 32'(NWIN));
      idle(3);

      // starvation: events held valid across a whole scan
      step(1'b1, 8'($urandom_range(0, W - 1)), 8'($urandom_range(0, H - 1)), 1'b1, 1'b0);
      for (i = 0; i < 5 * NTAP + 50; i++) begin
         step(1'b1, 8'($urandom_range(0, W - 1)), 8'($urandom_range(0, H - 1)), 1'b0, 1'b0);
         if (doneCyc >= 0 && !mScan) break;
      end
      checkVal("starveFinished", 32'(doneCyc >= 0), 32'd1);
      checkVal("starveDoneCycle", 32'(doneCyc - startCyc), 32'(5 * NTAP + 2));
      checkVal("starveWinCount", 32'(dutWinCnt), 32'(NWIN));
      idle(3);

      // reset in the middle of a scan
      step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
      for (i = 0; i < 9 * 100 + 50; i++) begin
         idle(1);
         if (dutWinCnt >= 100) break;
      end
      checkVal("reached100", 32'(dutWinCnt >= 100), 32'd1);
      step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
      idle(1);
      checkVal("abortBusy",  32'(bus.scanBusy),  32'd0);
      checkVal("abortValid", 32'(bus.winValid),  32'd0);
      checkVal("abortDone",  32'(bus.scanDone),  32'd0);
      checkVal("abortWin",   32'(bus.win),       32'd0);
      checkVal("abortWinX",  32'(bus.winX),      32'd0);
      checkVal("abortWinY",  32'(bus.winY),      32'd0);
      checkVal("abortMed",   32'(bus.winMedian), 32'd0);
      checkVal("abortDrop",  32'(bus.dropCount), 32'd0);
      checkVal("abortWrite", 32'(bus.ramWrite),  32'd0);
      winsBefore = dutWinCnt;
      idle(60);
      checkVal("noWinAfterAbort", 32'(dutWinCnt - winsBefore), 32'd0);

      // random traffic around a full scan, with stray scanStart pulses
      step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
      for (i = 0; i < 4 * NTAP; i++) begin
         step(($urandom_range(0, 1) == 1),
              ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, W - 1)),
              ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, H - 1)),
              ($urandom_range(0, 99) == 0), 1'b0);
         if (doneCyc >= 0 && !mScan) break;
      end
      checkVal("randFinished", 32'(doneCyc >= 0), 32'd1);
      checkVal("randWinCount", 32'(dutWinCnt), 32'(NWIN));
      for (i = 0; i < 20; i++)
         step(($urandom_range(0, 1) == 1), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end
endmodule
